wb_load_mux: RTL

- Parametrised write-back selector; successor to the two-input load/result mux.
- Chooses among NUM_SRC result sources (ALU, load, link, immediate, ...) and drives registered register-file write ports.
- Handles loads as split transactions: waits for the memory controller's return data, then sign- or zero-extends byte/half/word and writes it back.
- Sits between execute/memory-controller outputs and the register file; stalls issue while a load is outstanding.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/load_extend.sv | 23 ++
 rtl/wb_load_mux.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared encodings for the write-back load mux and load extender
package wb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_LDR = 1'b1
    } wb_state_e;

    localparam int SRC_ALU  = 0;
    localparam int SRC_LDR  = 1;
    localparam int SRC_LINK = 2;
    localparam int SRC_IMM  = 3;

    function automatic int sel_width(input int num_src);
        return (num_src > 2) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - combinational byte/half/word sign or zero extender
module load_extend
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        size,
    input  logic              is_signed,
    output logic [DATA_W-1:0] ext_data
);

    always_comb begin
        ext_data = rdata;
        case (size)
            SZ_BYTE: ext_data = {{(DATA_W-8){is_signed & rdata[7]}}, rdata[7:0]};
            SZ_HALF: ext_data = {{(DATA_W-16){is_signed & rdata[15]}}, rdata[15:0]};
            SZ_WORD: ext_data = rdata;
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_load_mux.sv
// rtl/wb_load_mux.sv - write-back source selector with split-transaction loads (optional WB_LOAD_TIMEOUT_EN)
module wb_load_mux
    import wb_pkg::*;
#(
    parameter int  DATA_W         = 32,
    parameter int  NUM_SRC        = 4,
    parameter int  LDR_SRC        = SRC_LDR,
    parameter int  REG_ADDR_W     = 4,
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int SEL_W          = sel_width(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [SEL_W-1:0]          issue_sel,
    input  logic [REG_ADDR_W-1:0]     issue_rd,
    input  logic [1:0]                issue_size,
    input  logic                      issue_signed,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      mem_rvalid,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      rf_we,
    output logic [REG_ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
`ifdef WB_LOAD_TIMEOUT_EN
    output logic                      ld_err,
`endif
    output logic                      stall
);

    wb_state_e             state_q, state_d;
    logic [REG_ADDR_W-1:0] ld_rd_q;
    logic [1:0]            ld_size_q;
    logic                  ld_signed_q;
    logic                  ld_accept;

    logic                  we_d;
    logic [REG_ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0]     wdata_d;
    logic [DATA_W-1:0]     sel_data;
    logic                  sel_hit;
    logic [DATA_W-1:0]     ext_data;
    logic                  timeout_hit;

    // Out-of-range selects leave sel_hit low so the request is consumed silently.
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (issue_sel == SEL_W'(k) && k != LDR_SRC) begin
                sel_data = src_data[k*DATA_W +: DATA_W];
                sel_hit  = 1'b1;
            end
        end
    end

    load_extend #(
        .DATA_W(DATA_W)
    ) u_load_extend (
        .rdata    (mem_rdata),
        .size     (ld_size_q),
        .is_signed(ld_signed_q),
        .ext_data (ext_data)
    );

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             tmo_last;

    assign tmo_last = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            ld_err    <= 1'b0;
        end else begin
            if (ld_accept) begin
                tmo_cnt_q <= '0;
            end else if (state_q == ST_WAIT_LDR && !mem_rvalid) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (timeout_hit) begin
                ld_err <= 1'b1;
            end
        end
    end
`else
    logic tmo_last;
    assign tmo_last = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        waddr_d     = rf_waddr;
        wdata_d     = rf_wdata;
        timeout_hit = 1'b0;
        ld_accept   = 1'b0;
        issue_ready = (state_q == ST_IDLE);
        stall       = (state_q == ST_WAIT_LDR);
        case (state_q)
            ST_IDLE: begin
                if (issue_valid) begin
                    if (issue_sel == SEL_W'(LDR_SRC)) begin
                        ld_accept = 1'b1;
                        state_d   = ST_WAIT_LDR;
                    end else if (sel_hit) begin
                        we_d    = 1'b1;
                        waddr_d = issue_rd;
                        wdata_d = sel_data;
                    end
                end
            end
            ST_WAIT_LDR: begin
                // Data arriving on the limit cycle still wins over the timeout.
                if (mem_rvalid) begin
                    we_d    = 1'b1;
                    waddr_d = ld_rd_q;
                    wdata_d = ext_data;
                    state_d = ST_IDLE;
                end else if (tmo_last) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            ld_rd_q     <= '0;
            ld_size_q   <= 2'b00;
            ld_signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rf_we    <= we_d;
            rf_waddr <= waddr_d;
            rf_wdata <= wdata_d;
            if (ld_accept) begin
                ld_rd_q     <= issue_rd;
                ld_size_q   <= issue_size;
                ld_signed_q <= issue_signed;
            end
        end
    end

endmodule
